regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Write-side initiator for the 32x32 register file's single write port (we/waddr/wdata).
//  Merges in-order writeback from the MEM/WB pipeline with out-of-band results from multi-cycle units (div/mult).
//  Pipeline writes have absolute priority; multi-cycle results queue in a small FIFO and drain in free cycles.
//  Exports a pending-register mask so ID can stall on operands with queued writes.
// PARAMETERS
//  DEPTH     4  multi-cycle write FIFO entries (power of 2, >=2)
//  DEPTH_LOG 2  log2(DEPTH)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  pipe_we     in   1   MEM/WB write request; no backpressure, always accepted
//  pipe_waddr  in   5   MEM/WB destination register
//  pipe_wdata  in   32  MEM/WB write data
//  mc_valid    in   1   multi-cycle unit write request valid
//  mc_waddr    in   5   multi-cycle destination register
//  mc_wdata    in   32  multi-cycle write data
//  mc_ready    out  1   FIFO can accept; transfer = mc_valid & mc_ready
//  we          out  1   regfile write enable (registered)
//  waddr       out  5   regfile write address (registered)
//  wdata       out  32  regfile write data (registered)
//  pend_mask   out  32  bit n=1: valid queued write to register n
//  q_count     out  DEPTH_LOG+1  valid+squashed entries held in FIFO
// BEHAVIOUR
//  Reset: we=0, waddr=0, wdata=0, FIFO empty, q_count=0, pend_mask=0; mc_ready=0 while rst=1.
//  Reset mid-operation discards all queued entries; no write issued in the reset cycle or the cycle after.
//  Output select each cycle (result on we/waddr/wdata next clk edge, latency 1):
//   1. pipe_we=1 & pipe_waddr!=0 -> issue pipe write; FIFO holds.
//   2. else FIFO non-empty -> pop head; issue it with we=1 if entry valid, we=0 if squashed.
//   3. else we=0 (waddr/wdata hold last value).
//  pipe_we=1 with pipe_waddr=0: no write issued, counts as idle cycle (FIFO may drain).
//  mc_ready = (q_count < DEPTH) & !rst, from registered count; push accepted when full+pop is NOT allowed.
//  Simultaneous push and pop: both occur, q_count unchanged; popped entry is the older head.
//  mc write to r0: handshake completes, nothing enqueued, no write ever issued.
//  FIFO: circular, wr_ptr/rd_ptr DEPTH_LOG bits, wrap modulo DEPTH; per-entry valid bit.
//  WAW squash: a pipe write to r (r!=0) clears valid on every queued entry with waddr=r in the same cycle.
//  mc push same cycle as pipe write to same r: entry enqueued already squashed (pipe wins).
//  pend_mask: combinational OR of one-hot(waddr) over valid entries; squashed entries excluded.
//  Entries drain strictly in FIFO order; squashed entries still consume one idle cycle.
// TESTING
//  pipe_we=1,waddr=5,wdata=0x00001234 -> next cycle we=1,waddr=5,wdata=0x00001234.
//  Pipe busy on r10 every cycle; push r1..r4 -> mc_ready=0 after 4th, q_count=4, pend_mask=0x0000001E;
//   pipe idle -> r1,r2,r3,r4 written on 4 consecutive cycles, then q_count=0, mc_ready=1.
//  Queue r7=0xAAAAAAAA, then pipe r7=0xBBBBBBBB -> pend_mask[7]=0 next cycle; only write to r7 carries 0xBBBBBBBB; squashed pop shows we=0.
//  pipe r0 -> we stays 0; mc r0 push -> q_count unchanged, pend_mask=0.
//  q_count=3, pipe idle, push r9 same cycle as pop -> q_count stays 3, head written, r9 at tail.
//  rst=1 with q_count=3 mid-drain -> next cycle we=0, q_count=0, pend_mask=0; mc_ready=1 once rst=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: priority write-port arbiter, pipeline first, multi-cycle results via squashable FIFO
module regfile_wr_arbiter #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_we,
  input  logic [4:0]           pipe_waddr,
  input  logic [31:0]          pipe_wdata,
  input  logic                 mc_valid,
  input  logic [4:0]           mc_waddr,
  input  logic [31:0]          mc_wdata,
  output logic                 mc_ready,
  output logic                 we,
  output logic [4:0]           waddr,
  output logic [31:0]          wdata,
  output logic [31:0]          pend_mask,
  output logic [DEPTH_LOG:0]   q_count
);
  localparam logic [DEPTH_LOG:0] FULL = DEPTH[DEPTH_LOG:0];
  logic [4:0]           addr_q [DEPTH];
  logic [31:0]          data_q [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]   cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 pipe_hit, pop, push;
  assign pipe_hit  = pipe_we & (pipe_waddr != 5'd0);
  assign pop       = !pipe_hit & (cnt_q != '0);
  assign mc_ready  = (cnt_q != FULL) & !rst;
  // r0 writes complete the handshake but never occupy a slot
  assign push      = mc_valid & mc_ready & (mc_waddr != 5'd0);
  assign cnt_d     = cnt_q + {{DEPTH_LOG{1'b0}}, push} - {{DEPTH_LOG{1'b0}}, pop};
  assign we_d      = pipe_hit | (pop & vld_q[rd_ptr_q]);
  assign waddr_d   = pipe_hit ? pipe_waddr : pop ? addr_q[rd_ptr_q] : waddr_q;
  assign wdata_d   = pipe_hit ? pipe_wdata : pop ? data_q[rd_ptr_q] : wdata_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign q_count   = cnt_q;
  // valid bits only live in occupied slots, so pend_mask can OR over all of them
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (pipe_hit && addr_q[i] == pipe_waddr) vld_d[i] = 1'b0;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = !(pipe_hit && pipe_waddr == mc_waddr);
  end
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) pend_mask[addr_q[i]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(push);
      rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(pop);
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= mc_waddr;
      data_q[wr_ptr_q] <= mc_wdata;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus with a write scoreboard checked by a negedge monitor
module tb_regfile_wr_arbiter;
  logic        clk = 0, rst = 1;
  logic        pipe_we = 0, mc_valid = 0;
  logic [4:0]  pipe_waddr = 0, mc_waddr = 0;
  logic [31:0] pipe_wdata = 0, mc_wdata = 0;
  logic        mc_ready, we;
  logic [4:0]  waddr;
  logic [31:0] wdata, pend_mask;
  logic [2:0]  q_count;
  int compared = 0, mismatched = 0;
  typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  regfile_wr_arbiter #(.DEPTH(4), .DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
    .mc_ready(mc_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we !== 1'b0) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL write: unexpected we=%b waddr=%0d wdata=%h", we, waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (we !== 1'b1 || waddr !== mon_e.a || wdata !== mon_e.d) begin
          mismatched++;
          $display("FAIL write: got r%0d=%h want r%0d=%h", waddr, wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{a, d});
  endtask

  task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    mc_valid = mv; mc_waddr = ma; mc_wdata = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_qcount", 32'(q_count), 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_mc_ready", 32'(mc_ready), 0);
    rst = 0;
    #1;
    chk("post_rst_mc_ready", 32'(mc_ready), 1);
    expect_wr(5, 32'h0000_1234);
    step(1, 5, 32'h0000_1234, 0, 0, 0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      chk("fill_mc_ready", 32'(mc_ready), 1);
      expect_wr(10, 32'h100 + 32'(i));
      step(1, 10, 32'h100 + 32'(i), 1, 5'(i), 32'h1111_0000 + 32'(i));
    end
    chk("full_mc_ready", 32'(mc_ready), 0);
    chk("full_qcount", 32'(q_count), 4);
    chk("full_pend", pend_mask, 32'h0000_001E);
    for (int i = 1; i <= 4; i++) expect_wr(5'(i), 32'h1111_0000 + 32'(i));
    repeat (4) idle();
    chk("drain_qcount", 32'(q_count), 0);
    chk("drain_mc_ready", 32'(mc_ready), 1);
    expect_wr(10, 32'h10A);
    step(1, 10, 32'h10A, 1, 7, 32'hAAAA_AAAA);
    chk("r7_queued_pend", pend_mask, 32'h0000_0080);
    expect_wr(7, 32'hBBBB_BBBB);
    step(1, 7, 32'hBBBB_BBBB, 0, 0, 0);
    chk("r7_squash_pend", pend_mask, 0);
    chk("r7_squash_qcount", 32'(q_count), 1);
    idle();
    chk("squashed_pop_we", 32'(we), 0);
    chk("squashed_pop_qcount", 32'(q_count), 0);
    step(1, 0, 32'hDEAD_BEEF, 0, 0, 0);
    chk("pipe_r0_we", 32'(we), 0);
    step(0, 0, 0, 1, 0, 32'h5555_5555);
    chk("mc_r0_qcount", 32'(q_count), 0);
    chk("mc_r0_pend", pend_mask, 0);
    chk("mc_r0_we", 32'(we), 0);
    expect_wr(10, 32'h10C);
    step(1, 10, 32'h10C, 1, 10, 32'h7777_7777);
    chk("same_cycle_squash_qcount", 32'(q_count), 1);
    chk("same_cycle_squash_pend", pend_mask, 0);
    idle();
    chk("same_cycle_squash_we", 32'(we), 0);
    for (int i = 0; i < 3; i++) begin
      expect_wr(10, 32'h200 + 32'(i));
      step(1, 10, 32'h200 + 32'(i), 1, 5'(11 + i), 32'h3000 + 32'(i));
    end
    chk("three_qcount", 32'(q_count), 3);
    chk("three_pend", pend_mask, 32'h0000_3800);
    expect_wr(11, 32'h3000);
    step(0, 0, 0, 1, 9, 32'h9999_9999);
    chk("pushpop_qcount", 32'(q_count), 3);
    chk("pushpop_pend", pend_mask, 32'h0000_3200);
    rst = 1;
    idle();
    chk("midrst_we", 32'(we), 0);
    chk("midrst_qcount", 32'(q_count), 0);
    chk("midrst_pend", pend_mask, 0);
    chk("midrst_mc_ready", 32'(mc_ready), 0);
    rst = 0;
    #1;
    chk("after_rst_mc_ready", 32'(mc_ready), 1);
    idle();
    chk("after_rst_we", 32'(we), 0);
    repeat (3) idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
